clk_divider_bank: RTL and testbench
===================================

CLK_DIVIDER_BANK -- requirements
Module: clk_divider_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CNT_W, default 8: divisor and counter width in bits, range 2..16.
REQ-003 Parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset, range 0..2^CNT_W-1.
REQ-004 clk  input  1  the single clock; all state SHALL be on its rising edge, with no derived or ripple clocks.
REQ-005 reset  input  1  asynchronous, active-low reset; asserts with no clock edge, deasserts synchronously with clk.
REQ-006 cfg_valid  input  1  a configuration write is offered.
REQ-007 cfg_ready  output  1  a write can be accepted this cycle.
REQ-008 cfg_chan  input  4  target channel index.
REQ-009 cfg_div  input  CNT_W  new divisor D.
REQ-010 sync  input  1  single-cycle phase-realign request for all channels.
REQ-011 tick  output  CHANNELS  per-channel one-cycle enable pulse, one per period.
REQ-012 div_out  output  CHANNELS  per-channel divided square wave, used as data only, never as a clock.

Function
REQ-013 Each channel SHALL hold divisor D, counter cnt (CNT_W bits), pending flag pend and pending divisor pdiv.
REQ-014 D=0: channel disabled; cnt SHALL hold at 0 and tick[i]=0, div_out[i]=0.
REQ-015 D>=1: cnt SHALL step 0,1,...,D-1 and wrap to 0, one step per clk.
REQ-016 tick[i] SHALL be high exactly in cycles where cnt==D-1 (D>=1); D=1 SHALL give tick high every cycle.
REQ-017 div_out[i] SHALL be high while cnt < ceil(D/2), else low, so high time is ceil(D/2) cycles and low time is floor(D/2) cycles; D=1 SHALL give a constant 1.
REQ-018 Outputs SHALL be decoded only from registered state; cfg and sync inputs SHALL NOT reach tick or div_out combinationally.
REQ-019 Handshake: a write is accepted when cfg_valid && cfg_ready at a clk edge; cfg_ready = ~pend[cfg_chan], and cfg_ready SHALL be 1 when cfg_chan >= CHANNELS.
REQ-020 Accepted write to an out-of-range channel SHALL be consumed with no state change.
REQ-021 Accepted write to a channel with D=0 SHALL load D=cfg_div and cnt=0 at that edge, with no pend.
REQ-022 Accepted write to a running channel SHALL set pend=1 and pdiv=cfg_div; at the next wrap edge (cnt==D-1) D<=pdiv, cnt<=0, pend<=0, so no runt or stretched period occurs.
REQ-023 An accepted write arriving on the wrap edge itself SHALL take effect immediately at that edge, with pend left 0.
REQ-024 sync=1 at an edge SHALL set cnt=0 in every channel, apply every pending pdiv, and clear all pend.
REQ-025 sync and an accepted write at the same edge: the written value SHALL be applied directly to D with cnt=0; sync takes precedence over deferral.
REQ-026 Writing a new D smaller than the current cnt is only possible via REQ-021 or REQ-024, both of which zero cnt; cnt SHALL never exceed D-1.

Reset
REQ-027 While reset=0: every D=DEFAULT_DIV, cnt=0, pend=0, pdiv=0, regardless of clk.
REQ-028 Reset outputs SHALL follow from REQ-016/017 with cnt=0; with default DEFAULT_DIV=2: tick=0, div_out=all ones, cfg_ready=1.
REQ-029 Reset asserted mid-period SHALL abort any pending update with no deferred effect after release.

Verification
REQ-030 Release reset (defaults): ch0 div_out = 1,0,1,0... from first cycle; tick = 0,1,0,1...; all channels identical.
REQ-031 ch1 at D=2, write D=5 at cnt=0 -> cfg_ready low 1 cycle; after wrap, tick every 5 cycles; div_out high 3, low 2.
REQ-032 Write D=1 to ch2 -> tick constant 1, div_out constant 1; write D=0 -> both 0 after the next wrap; write D=3 -> immediate start at cnt=0.
REQ-033 ch0 D=4, ch1 D=6 at arbitrary phases, pulse sync -> both cnt=0 next cycle; coincident ticks every 12 cycles thereafter.
REQ-034 Pending write on ch3 plus sync in same cycle as new write to ch0 -> both applied at that edge, pend all 0.
REQ-035 Assert reset between clk edges mid-period -> outputs reach reset values without a clk edge; pend cleared; write with cfg_chan=7 -> accepted, no change.

Source files
------------

// File: rtl/clk_divider_bank.sv
// Bank of independent counter-based clock dividers producing tick enables and divided
// square waves as data, with glitch-free deferred divisor updates and a global phase sync.
module clk_divider_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                sync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] div_out
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  logic [CHANNELS-1:0] pend_vec;
  logic                accept;

  // Channels beyond CHANNELS always look ready so their writes are simply consumed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == 4'(i)) cfg_ready = ~pend_vec[i];
    end
  end

  assign accept = cfg_valid & cfg_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             run, wrap, wr;
    logic [CNT_W:0]   half;

    assign run  = (div_q != '0);
    assign wrap = run && (cnt_q == div_q - CntOne);
    assign wr   = accept && (cfg_chan == 4'(g));
    assign half = ({1'b0, div_q} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    assign pend_vec[g] = pend_q;
    assign tick[g]     = wrap;
    assign div_out[g]  = run && ({1'b0, cnt_q} < half);

    always_comb begin
      div_d  = div_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      if (!run || wrap) cnt_d = '0;
      else              cnt_d = cnt_q + CntOne;
      if ((wrap || sync) && pend_q) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
      if (sync) cnt_d = '0;
      // A write can only land directly when the period boundary is now; otherwise defer.
      if (wr) begin
        if (sync || !run || wrap) begin
          div_d  = cfg_div;
          cnt_d  = '0;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b1;
          pdiv_d = cfg_div;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        div_q  <= DefDiv;
        cnt_q  <= '0;
        pdiv_q <= '0;
        pend_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: vector table for the basic cycle-by-cycle behaviour,
// then hand-written sequences for sync alignment, sync-with-write and mid-period reset.
module tb_clk_divider_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_chan;
  logic [7:0] cfg_div;
  logic       sync;
  logic [3:0] tick;
  logic [3:0] div_out;

  int tests = 0;
  int fails = 0;

  clk_divider_bank dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .sync      (sync),
    .tick      (tick),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] chan;
    logic [7:0] div;
    logic       sync;
    logic       ready;
    logic [3:0] tick;
    logic [3:0] dout;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs describe the current cycle, before the edge that consumes the inputs.
    vecs[0]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[1]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b1111, 4'b0000};
    vecs[2]  = '{1'b1, 4'd1, 8'd5, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[3]  = '{1'b0, 4'd1, 8'd0, 1'b0, 1'b0, 4'b1111, 4'b0000};
    vecs[4]  = '{1'b0, 4'd1, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[5]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b1101, 4'b0010};
    vecs[6]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[7]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b1101, 4'b0000};
    vecs[8]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b0010, 4'b1101};
    vecs[9]  = '{1'b1, 4'd2, 8'd1, 1'b0, 1'b1, 4'b1101, 4'b0010};
    vecs[10] = '{1'b1, 4'd2, 8'd0, 1'b0, 1'b1, 4'b0100, 4'b1111};
    vecs[11] = '{1'b1, 4'd2, 8'd3, 1'b0, 1'b1, 4'b1001, 4'b0010};
    vecs[12] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b0000, 4'b1101};
    vecs[13] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b1011, 4'b0100};
    vecs[14] = '{1'b1, 4'd0, 8'd4, 1'b0, 1'b1, 4'b0100, 4'b1011};
    vecs[15] = '{1'b1, 4'd0, 8'd9, 1'b0, 1'b0, 4'b1001, 4'b0110};
    vecs[16] = '{1'b1, 4'd1, 8'd6, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[17] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b1100, 4'b0001};
    vecs[18] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'b0010, 4'b1100};
    vecs[19] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'b1001, 4'b0110};

    reset = 1'b0; cfg_valid = 1'b0; cfg_chan = 4'd0; cfg_div = 8'd0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tick", tick, 4'b0000);
    chk("reset div_out", div_out, 4'b1111);
    chk("reset ready", {3'b000, cfg_ready}, 4'd1);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cfg_valid = vecs[i].valid;
      cfg_chan  = vecs[i].chan;
      cfg_div   = vecs[i].div;
      sync      = vecs[i].sync;
      #1;
      chk($sformatf("vec%0d ready", i), {3'b000, cfg_ready}, {3'b000, vecs[i].ready});
      chk($sformatf("vec%0d tick", i), tick, vecs[i].tick);
      chk($sformatf("vec%0d div_out", i), div_out, vecs[i].dout);
      cyc();
    end
    cfg_valid = 1'b0; sync = 1'b0;

    // After sync: ch0 D=4, ch1 D=6 from cnt=0, so ticks coincide every 12th cycle.
    for (int k = 0; k < 24; k++) begin
      #1;
      chk($sformatf("sync k%0d tick0", k), {3'b000, tick[0]}, {3'b000, (k % 4) == 3});
      chk($sformatf("sync k%0d coincide", k), {3'b000, tick[0] & tick[1]},
          {3'b000, (k % 12) == 11});
      cyc();
    end

    // Give ch3 a long period, then leave a pending update on it.
    cfg_valid = 1'b1; cfg_chan = 4'd3; cfg_div = 8'd7;
    #1; chk("ch3 wr7 ready", {3'b000, cfg_ready}, 4'd1); cyc();
    cfg_valid = 1'b0;
    #1; chk("ch3 pend7 ready", {3'b000, cfg_ready}, 4'd0); cyc();
    cfg_valid = 1'b1; cfg_div = 8'd3;
    #1; chk("ch3 wr3 ready", {3'b000, cfg_ready}, 4'd1); cyc();
    cfg_valid = 1'b0;
    #1; chk("ch3 pend3 ready", {3'b000, cfg_ready}, 4'd0); cyc();
    cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_div = 8'd5; sync = 1'b1;
    #1; chk("ch0 wr5 ready", {3'b000, cfg_ready}, 4'd1); cyc();
    cfg_valid = 1'b0; sync = 1'b0;
    #1;
    chk("post sync tick", tick, 4'b0000);
    chk("post sync div_out", div_out, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      cfg_chan = 4'(c);
      #1; chk($sformatf("post sync ready ch%0d", c), {3'b000, cfg_ready}, 4'd1);
    end
    cyc();
    #1;
    chk("post sync+1 tick", tick, 4'b0000);
    chk("post sync+1 div_out", div_out, 4'b1111);
    cyc();
    cfg_valid = 1'b1; cfg_chan = 4'd1; cfg_div = 8'd9;
    #1;
    chk("post sync+2 tick", tick, 4'b1100);
    chk("post sync+2 div_out", div_out, 4'b0011);
    chk("ch1 wr9 ready", {3'b000, cfg_ready}, 4'd1);
    cyc();
    cfg_valid = 1'b0;
    #1; chk("ch1 pend9 ready", {3'b000, cfg_ready}, 4'd0);

    // Reset between edges must act immediately and drop the pending update.
    #1; reset = 1'b0;
    #1;
    chk("async reset tick", tick, 4'b0000);
    chk("async reset div_out", div_out, 4'b1111);
    chk("async reset ready", {3'b000, cfg_ready}, 4'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel c0 tick", tick, 4'b0000);
    chk("rel c0 div_out", div_out, 4'b1111);
    cyc();
    chk("rel c1 tick", tick, 4'b1111);
    chk("rel c1 div_out", div_out, 4'b0000);
    cyc();
    cfg_valid = 1'b1; cfg_chan = 4'd7; cfg_div = 8'd0;
    #1;
    chk("rel c2 tick", tick, 4'b0000);
    chk("rel c2 div_out", div_out, 4'b1111);
    chk("chan7 ready", {3'b000, cfg_ready}, 4'd1);
    cyc();
    cfg_valid = 1'b0; cfg_chan = 4'd0;
    #1;
    chk("rel c3 tick", tick, 4'b1111);
    chk("rel c3 div_out", div_out, 4'b0000);
    chk("rel c3 ready", {3'b000, cfg_ready}, 4'd1);
    cyc();
    #1;
    chk("rel c4 tick", tick, 4'b0000);
    chk("rel c4 div_out", div_out, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
